mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the MEM-stage handshake and data buses.
//   exe_to_mem_valid/exe_to_mem_bus : instruction from EXE (74-bit bus)
//   mem_allowin                     : MEM can accept this cycle
//   data_sram_rdata                 : synchronous SRAM read data
//   wb_allowin                      : WB can accept
//   mem_to_wb_valid/mem_to_wb_bus   : completed instruction to WB (70-bit bus)
//   gr_we_mem/dest_mem/mem_fwd_data : bypass info for decode
// master = surrounding pipeline / bench, slave = mem_stage.
interface mem_stage_if;
  logic        exe_to_mem_valid;
  logic [73:0] exe_to_mem_bus;
  logic        mem_allowin;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic        gr_we_mem;
  logic [4:0]  dest_mem;
  logic [31:0] mem_fwd_data;

  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus, gr_we_mem, dest_mem, mem_fwd_data
  );

  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, data_sram_rdata, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus, gr_we_mem, dest_mem, mem_fwd_data
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//   clk, resetn : clock and asynchronous active-low reset
//   mem_if      : mem_stage_if.slave (EXE input, WB output, SRAM read data, bypass)
// Holds one instruction, extends load data by mem_op and forwards the result to WB.
// SRAM data is live only in the first occupancy cycle; a stall buffers it.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  mem_stage_if.slave  mem_if
);

  logic        r_mem_valid;
  logic [73:0] r_bus;
  logic        r_held;
  logic [31:0] r_rdata_buf;

  logic        w_allowin;
  logic        w_accept;
  logic [2:0]  w_mem_op;
  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_final;

  assign w_allowin = !r_mem_valid || mem_if.wb_allowin;
  assign w_accept  = mem_if.exe_to_mem_valid && w_allowin;

  assign {w_mem_op, w_res_from_mem, w_gr_we, w_dest, w_alu_result, w_pc} = r_bus;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_valid <= 1'b0;
      r_bus       <= '0;
      r_held      <= 1'b0;
      r_rdata_buf <= '0;
    end else begin
      if (w_allowin) begin
        r_mem_valid <= mem_if.exe_to_mem_valid;
      end
      if (w_accept) begin
        r_bus  <= mem_if.exe_to_mem_bus;
        r_held <= 1'b0;
      end else if (r_mem_valid && !mem_if.wb_allowin && !r_held) begin
        // First stalled cycle: the SRAM output will not stay put, so capture it now.
        r_rdata_buf <= mem_if.data_sram_rdata;
        r_held      <= 1'b1;
      end
    end
  end

  assign w_raw = r_held ? r_rdata_buf : mem_if.data_sram_rdata;

  always_comb begin
    w_byte = w_raw[7:0];
    unique case (w_alu_result[1:0])
      2'b00: w_byte = w_raw[7:0];
      2'b01: w_byte = w_raw[15:8];
      2'b10: w_byte = w_raw[23:16];
      2'b11: w_byte = w_raw[31:24];
      default: w_byte = w_raw[7:0];
    endcase
  end

  // Halfword alignment ignores address bit 0.
  assign w_half = w_alu_result[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_load = w_raw;
    case (w_mem_op)
      3'b001:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load = {24'b0, w_byte};
      3'b011:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {16'b0, w_half};
      default: w_load = w_raw;
    endcase
  end

  assign w_final = w_res_from_mem ? w_load : w_alu_result;

  assign mem_if.mem_allowin     = w_allowin;
  assign mem_if.mem_to_wb_valid = r_mem_valid;
  assign mem_if.mem_to_wb_bus   = {w_gr_we, w_dest, w_final, w_pc};
  assign mem_if.gr_we_mem       = r_mem_valid & w_gr_we;
  assign mem_if.dest_mem        = r_mem_valid ? w_dest : 5'b0;
  assign mem_if.mem_fwd_data    = w_final;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven self-checking bench for mem_stage.
module tb_mem_stage;

  logic clk;
  logic resetn;

  mem_stage_if u_if ();

  mem_stage u_dut (
    .clk    (clk),
    .resetn (resetn),
    .mem_if (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic        res;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [73:0] mk_bus(input logic [2:0] op, input logic res, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {op, res, we, dest, alu, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [73:0] b);
    u_if.exe_to_mem_valid = v;
    u_if.exe_to_mem_bus   = b;
  endtask

  function automatic logic [31:0] res_of();
    return u_if.mem_to_wb_bus[63:32];
  endfunction

  function automatic logic [31:0] pc_of();
    return u_if.mem_to_wb_bus[31:0];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'b000, 1'b1, 1'b1, 5'd1,  32'h0000_1000, 32'h1c00_0010, 32'h8899_AABB, 32'h8899_AABB};
    vecs[1]  = '{3'b001, 1'b1, 1'b1, 5'd2,  32'h0000_1002, 32'h1c00_0014, 32'h80FF_7F01, 32'hFFFF_FFFF};
    vecs[2]  = '{3'b010, 1'b1, 1'b1, 5'd3,  32'h0000_1003, 32'h1c00_0018, 32'h80FF_7F01, 32'h0000_0080};
    vecs[3]  = '{3'b011, 1'b1, 1'b1, 5'd4,  32'h0000_1000, 32'h1c00_001c, 32'h80FF_7F01, 32'h0000_7F01};
    vecs[4]  = '{3'b100, 1'b1, 1'b1, 5'd5,  32'h0000_1002, 32'h1c00_0020, 32'h80FF_7F01, 32'h0000_80FF};
    vecs[5]  = '{3'b001, 1'b1, 1'b1, 5'd6,  32'h0000_1000, 32'h1c00_0024, 32'h80FF_7F01, 32'h0000_0001};
    vecs[6]  = '{3'b001, 1'b1, 1'b0, 5'd7,  32'h0000_1003, 32'h1c00_0028, 32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[7]  = '{3'b010, 1'b1, 1'b1, 5'd8,  32'h0000_1001, 32'h1c00_002c, 32'h80FF_7F01, 32'h0000_007F};
    vecs[8]  = '{3'b011, 1'b1, 1'b1, 5'd9,  32'h0000_1003, 32'h1c00_0030, 32'h80FF_7F01, 32'hFFFF_80FF};
    vecs[9]  = '{3'b100, 1'b1, 1'b1, 5'd10, 32'h0000_1001, 32'h1c00_0034, 32'h80FF_7F01, 32'h0000_7F01};
    vecs[10] = '{3'b101, 1'b1, 1'b1, 5'd11, 32'h0000_1002, 32'h1c00_0038, 32'h80FF_7F01, 32'h80FF_7F01};
    vecs[11] = '{3'b111, 1'b1, 1'b1, 5'd12, 32'h0000_1001, 32'h1c00_003c, 32'h80FF_7F01, 32'h80FF_7F01};
    vecs[12] = '{3'b000, 1'b0, 1'b1, 5'd13, 32'h1234_5678, 32'h1c00_0040, 32'hCAFE_F00D, 32'h1234_5678};
    vecs[13] = '{3'b001, 1'b0, 1'b1, 5'd31, 32'hABCD_EF03, 32'h1c00_0044, 32'h80FF_7F01, 32'hABCD_EF03};

    resetn = 1'b0;
    drive(1'b0, '0);
    u_if.data_sram_rdata = 32'h0;
    u_if.wb_allowin      = 1'b1;
    #12;
    chk("rst_valid",   {31'b0, u_if.mem_to_wb_valid}, 32'd0);
    chk("rst_allowin", {31'b0, u_if.mem_allowin},     32'd1);
    chk("rst_gr_we",   {31'b0, u_if.gr_we_mem},       32'd0);
    chk("rst_dest",    {27'b0, u_if.dest_mem},        32'd0);
    chk("rst_pc",      pc_of(),                       32'd0);
    resetn = 1'b1;
    step();

    // Table: accept, present SRAM data one cycle later, check, drain.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, mk_bus(vecs[i].op, vecs[i].res, vecs[i].we, vecs[i].dest, vecs[i].alu,
                         vecs[i].pc));
      u_if.data_sram_rdata = 32'h0;
      u_if.wb_allowin      = 1'b1;
      step();
      drive(1'b0, '0);
      u_if.data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, u_if.mem_to_wb_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), res_of(), vecs[i].exp);
      chk($sformatf("v%0d_fwd", i), u_if.mem_fwd_data, vecs[i].exp);
      chk($sformatf("v%0d_pc", i), pc_of(), vecs[i].pc);
      chk($sformatf("v%0d_gr_we", i), {31'b0, u_if.gr_we_mem}, {31'b0, vecs[i].we});
      chk($sformatf("v%0d_dest", i), {27'b0, u_if.dest_mem}, {27'b0, vecs[i].dest});
      chk($sformatf("v%0d_wb_dest", i), {27'b0, u_if.mem_to_wb_bus[68:64]},
          {27'b0, vecs[i].dest});
      step();
      chk($sformatf("v%0d_drained", i), {31'b0, u_if.mem_to_wb_valid}, 32'd0);
    end

    // Stall hold: SRAM data changes after the first cycle but the result must not.
    drive(1'b1, mk_bus(3'b000, 1'b1, 1'b1, 5'd3, 32'h0000_2000, 32'h1c00_0100));
    u_if.wb_allowin = 1'b0;
    step();
    drive(1'b1, mk_bus(3'b000, 1'b0, 1'b1, 5'd4, 32'h0000_0BAD, 32'h1c00_0BAD));
    u_if.data_sram_rdata = 32'h1122_3344;
    #1;
    chk("stall_c0_result",  res_of(), 32'h1122_3344);
    chk("stall_c0_allowin", {31'b0, u_if.mem_allowin}, 32'd0);
    for (int c = 1; c < 3; c++) begin
      step();
      u_if.data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk($sformatf("stall_c%0d_result", c), res_of(), 32'h1122_3344);
      chk($sformatf("stall_c%0d_allowin", c), {31'b0, u_if.mem_allowin}, 32'd0);
      chk($sformatf("stall_c%0d_valid", c), {31'b0, u_if.mem_to_wb_valid}, 32'd1);
      chk($sformatf("stall_c%0d_pc", c), pc_of(), 32'h1c00_0100);
    end
    drive(1'b0, '0);
    u_if.wb_allowin = 1'b1;
    #1;
    chk("stall_rel_allowin", {31'b0, u_if.mem_allowin}, 32'd1);
    chk("stall_rel_result",  res_of(), 32'h1122_3344);
    step();
    chk("drain_valid",   {31'b0, u_if.mem_to_wb_valid}, 32'd0);
    chk("drain_keep_pc", pc_of(), 32'h1c00_0100);

    // Back-to-back ALU ops, no bubble.
    drive(1'b1, mk_bus(3'b000, 1'b0, 1'b1, 5'd1, 32'h0000_000A, 32'h0000_0100));
    step();
    drive(1'b1, mk_bus(3'b000, 1'b0, 1'b1, 5'd2, 32'h0000_000B, 32'h0000_0104));
    chk("b2b_a_valid", {31'b0, u_if.mem_to_wb_valid}, 32'd1);
    chk("b2b_a_pc",    pc_of(), 32'h0000_0100);
    step();
    drive(1'b0, '0);
    chk("b2b_b_valid", {31'b0, u_if.mem_to_wb_valid}, 32'd1);
    chk("b2b_b_pc",    pc_of(), 32'h0000_0104);
    chk("b2b_b_res",   res_of(), 32'h0000_000B);
    step();
    chk("b2b_end_valid", {31'b0, u_if.mem_to_wb_valid}, 32'd0);

    // Drain and fill in one edge while the old load's data is buffered.
    drive(1'b1, mk_bus(3'b000, 1'b1, 1'b1, 5'd5, 32'h0000_3000, 32'h1c00_0200));
    u_if.wb_allowin = 1'b0;
    step();
    drive(1'b0, '0);
    u_if.data_sram_rdata = 32'hAAAA_0001;
    step();
    drive(1'b1, mk_bus(3'b000, 1'b1, 1'b1, 5'd6, 32'h0000_3004, 32'h1c00_0204));
    u_if.wb_allowin = 1'b1;
    #1;
    chk("df_old_res", res_of(), 32'hAAAA_0001);
    step();
    drive(1'b0, '0);
    u_if.data_sram_rdata = 32'h5566_7788;
    #1;
    chk("df_new_valid", {31'b0, u_if.mem_to_wb_valid}, 32'd1);
    chk("df_new_pc",    pc_of(), 32'h1c00_0204);
    chk("df_new_res",   res_of(), 32'h5566_7788);
    step();

    // Forwarding outputs clear when the stage empties.
    drive(1'b1, mk_bus(3'b000, 1'b0, 1'b1, 5'd7, 32'h0000_0077, 32'h0000_0200));
    step();
    drive(1'b0, '0);
    chk("fwd_gr_we", {31'b0, u_if.gr_we_mem}, 32'd1);
    chk("fwd_dest",  {27'b0, u_if.dest_mem},  32'd7);
    step();
    chk("fwd_gr_we_off", {31'b0, u_if.gr_we_mem}, 32'd0);
    chk("fwd_dest_off",  {27'b0, u_if.dest_mem},  32'd0);

    // Asynchronous reset while a stalled load is held.
    drive(1'b1, mk_bus(3'b000, 1'b1, 1'b1, 5'd9, 32'h0000_4000, 32'h1c00_0300));
    u_if.wb_allowin = 1'b0;
    step();
    drive(1'b0, '0);
    u_if.data_sram_rdata = 32'h0BAD_0BAD;
    step();
    step();
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid",   {31'b0, u_if.mem_to_wb_valid}, 32'd0);
    chk("arst_allowin", {31'b0, u_if.mem_allowin},     32'd1);
    chk("arst_dest",    {27'b0, u_if.dest_mem},        32'd0);
    step();
    resetn = 1'b1;
    u_if.wb_allowin = 1'b1;
    step();
    drive(1'b1, mk_bus(3'b010, 1'b1, 1'b1, 5'd10, 32'h0000_5003, 32'h1c00_0400));
    step();
    drive(1'b0, '0);
    u_if.data_sram_rdata = 32'hF100_0000;
    #1;
    chk("post_rst_valid", {31'b0, u_if.mem_to_wb_valid}, 32'd1);
    chk("post_rst_res",   res_of(), 32'h0000_00F1);
    chk("post_rst_pc",    pc_of(), 32'h1c00_0400);
    step();
    chk("post_rst_drain", {31'b0, u_if.mem_to_wb_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
